mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-ported memory arbiter between the instruction and data sides of the cache block and the system RAM. Accepts independent instruction-fetch and data load/store requests and grants one at a time, data first, with a starvation guard for fetches. Drives the RAM request lines and returns per-requester wait/load. Sits between the caches block and the RAM model in the processor top level.

## Interface
- STARVE_MAX, 4: consecutive data-over-instruction wins before instruction is forced to win (1..15).
- TIMEOUT, 64: cycles without ramack before an access is abandoned (2..255).
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  reset; synchronous, active-low.
- iREN  in  1  instruction read request, held until iwait low.
- iaddr  in  32  instruction word address.
- iwait  out  1  low for exactly the cycle an instruction read completes.
- iload  out  32  instruction read data, valid when iwait low.
- dREN, dWEN  in  1 each  data read/write request; never both high.
- daddr, dstore  in  32 each  data address, write data.
- dwait  out  1  low for exactly the cycle a data access completes.
- dload  out  32  data read data, valid when dwait low.
- ramREN, ramWEN  out  1 each  RAM read/write strobe.
- ramaddr, ramstore  out  32 each  RAM address, write data.
- ramload  in  32  RAM read data, valid with ramack.
- ramack  in  1  RAM completion, one cycle per access.
- timeout_err  out  1  sticky; set when an access is abandoned.

## Operation
- States: IDLE, IACC, DACC (arb_state_t).
- IDLE: if (dREN|dWEN) and not starved -> DACC; else if iREN -> IACC; else stay. Starved = iREN and scount==STARVE_MAX.
- On grant: latch address (and dstore, write flag for data) into holding registers; clear cycle counter.
- scount: increments when both sides request in IDLE and data wins; clears when instruction is granted or iREN low in IDLE; saturates at STARVE_MAX.
- IACC: ramREN=1, ramaddr=latched iaddr. On ramack: iwait=0, -> IDLE.
- DACC: ramREN or ramWEN per latched flag, ramaddr/ramstore from latched values. On ramack: dwait=0, -> IDLE.
- Requester drops request mid-access: RAM access still runs to ramack; wait still pulses low (ignored by requester); no retry.
- Cycle counter in IACC/DACC; reaching TIMEOUT without ramack: set timeout_err, no wait pulse, -> IDLE.
- iload = dload = ramload (combinational pass-through).
- iwait = ~(state==IACC & ramack); dwait = ~(state==DACC & ramack).
- RAM strobes are zero in IDLE.

## Timing
- Reset values: state IDLE, scount 0, counter 0, latched regs 0, timeout_err 0; hence ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1.
- Request seen in IDLE at cycle n -> RAM strobe asserted cycle n+1; completion in the ramack cycle (earliest n+1).
- After completion the arbiter spends one IDLE cycle; back-to-back accesses cost ack latency + 1.
- Simultaneous iREN and dREN/dWEN: data wins unless starved.
- ramack in IDLE: ignored.
- ramack on the TIMEOUT cycle: completion wins; timeout_err not set.
- Reset asserted mid-access: next edge forces reset values; the in-flight access is dropped without a wait pulse.

## Structure
- arb_state_t (IDLE, IACC, DACC) added to cpu_types_pkg; word_t used for all 32-bit buses.
- No sub-module: the FSM, scount, and timeout counter are small enough to stay inline.

## Test plan
- Reset, then iREN with iaddr=0x40, RAM ack 2 cycles after strobe -> ramREN high from cycle 1, ramaddr=0x40, iwait low one cycle, iload=ramload=0x8C220004.
- dWEN with daddr=0x100, dstore=0xDEADBEEF, plus iREN, same cycle -> data granted first (ramWEN, ramstore=0xDEADBEEF); fetch follows after one IDLE cycle.
- dREN held continuously, iREN held, STARVE_MAX=4 -> 4 data grants, then 1 instruction grant, then data resumes.
- RAM never acks, TIMEOUT=64 -> strobe held 64 cycles, timeout_err=1, iwait stays 1, state IDLE; ack on cycle 64 in a rerun -> normal completion, timeout_err=0.
- nRST low two cycles into DACC -> next cycle ramWEN=0, dwait=1, timeout_err=0; new dREN after release is served normally.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared processor types: the 32-bit bus word and the memory arbiter state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data load/store; data has priority,
// with a starvation guard that forces a fetch after STARVE_MAX consecutive data wins.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  iREN,
  input  word_t iaddr,
  output logic  iwait,
  output word_t iload,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  output logic  dwait,
  output word_t dload,
  output logic  ramREN,
  output logic  ramWEN,
  output word_t ramaddr,
  output word_t ramstore,
  input  word_t ramload,
  input  logic  ramack,
  output logic  timeout_err
);

  arb_state_t r_state;
  arb_state_t w_next;
  logic [3:0] r_scount;
  logic [7:0] r_count;
  word_t      r_addr;
  word_t      r_store;
  logic       r_wen;
  logic       r_timeoutErr;

  logic w_dreq;
  logic w_starved;
  logic w_grantI;
  logic w_grantD;
  logic w_timeout;

  assign w_dreq    = dREN | dWEN;
  assign w_starved = iREN && (r_scount == 4'(STARVE_MAX));

  always_comb begin
    w_next    = r_state;
    w_grantI  = 1'b0;
    w_grantD  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_dreq && !w_starved) begin
          w_next   = DACC;
          w_grantD = 1'b1;
        end else if (iREN) begin
          w_next   = IACC;
          w_grantI = 1'b1;
        end
      end
      IACC, DACC: begin
        // An ack on the final allowed cycle still counts as a normal completion.
        if (ramack) begin
          w_next = IDLE;
        end else if (r_count == 8'(TIMEOUT - 1)) begin
          w_next    = IDLE;
          w_timeout = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_scount     <= '0;
      r_count      <= '0;
      r_addr       <= '0;
      r_store      <= '0;
      r_wen        <= 1'b0;
      r_timeoutErr <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grantD) begin
        r_addr  <= daddr;
        r_store <= dstore;
        r_wen   <= dWEN;
        r_count <= '0;
      end else if (w_grantI) begin
        r_addr  <= iaddr;
        r_wen   <= 1'b0;
        r_count <= '0;
      end else if (r_state != IDLE) begin
        r_count <= r_count + 8'd1;
      end
      // Starvation count only moves while arbitrating in IDLE.
      if (r_state == IDLE) begin
        if (!iREN || w_grantI) begin
          r_scount <= '0;
        end else if (w_grantD && (r_scount != 4'(STARVE_MAX))) begin
          r_scount <= r_scount + 4'd1;
        end
      end
      if (w_timeout) begin
        r_timeoutErr <= 1'b1;
      end
    end
  end

  assign ramREN      = (r_state == IACC) || ((r_state == DACC) && !r_wen);
  assign ramWEN      = (r_state == DACC) && r_wen;
  assign ramaddr     = r_addr;
  assign ramstore    = r_store;
  assign iload       = ramload;
  assign dload       = ramload;
  assign iwait       = !((r_state == IACC) && ramack);
  assign dwait       = !((r_state == DACC) && ramack);
  assign timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single fetch, data priority, starvation guard,
// timeout and completion on the last allowed cycle, and reset during an access.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic  CLK;
  logic  nRST;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;
  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  logic  dwait;
  word_t dload;
  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;
  logic  ramack;
  logic  timeout_err;

  int testsRun;
  int testsFailed;

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(64)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramack(ramack), .timeout_err(timeout_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic i, input word_t ia, input logic dr,
                               input logic dw, input word_t da, input word_t ds);
    iREN   = i;
    iaddr  = ia;
    dREN   = dr;
    dWEN   = dw;
    daddr  = da;
    dstore = ds;
  endtask

  initial begin
    int strobeCycles;
    int iwaitLow;
    logic [31:0] expAddr;
    testsRun    = 0;
    testsFailed = 0;
    nRST    = 1'b0;
    ramack  = 1'b0;
    ramload = '0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);

    // Reset state
    step();
    step();
    checkOutput("rst_ramREN", 32'(ramREN), 32'd0);
    checkOutput("rst_ramWEN", 32'(ramWEN), 32'd0);
    checkOutput("rst_ramaddr", ramaddr, 32'd0);
    checkOutput("rst_ramstore", ramstore, 32'd0);
    checkOutput("rst_iwait", 32'(iwait), 32'd1);
    checkOutput("rst_dwait", 32'(dwait), 32'd1);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
    nRST = 1'b1;

    // ramack while idle is ignored
    ramack = 1'b1;
    #1;
    checkOutput("idle_ack_iwait", 32'(iwait), 32'd1);
    checkOutput("idle_ack_dwait", 32'(dwait), 32'd1);
    ramack = 1'b0;

    // Single instruction fetch, ack two cycles after the strobe
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, '0, '0);
    step();
    checkOutput("if_ramREN_c1", 32'(ramREN), 32'd1);
    checkOutput("if_ramaddr", ramaddr, 32'h40);
    checkOutput("if_iwait_c1", 32'(iwait), 32'd1);
    step();
    checkOutput("if_ramREN_c2", 32'(ramREN), 32'd1);
    step();
    ramack  = 1'b1;
    ramload = 32'h8C220004;
    #1;
    checkOutput("if_iwait_ack", 32'(iwait), 32'd0);
    checkOutput("if_iload", iload, 32'h8C220004);
    checkOutput("if_dwait_ack", 32'(dwait), 32'd1);
    iREN = 1'b0;
    step();
    ramack = 1'b0;
    checkOutput("if_idle_ramREN", 32'(ramREN), 32'd0);
    checkOutput("if_idle_iwait", 32'(iwait), 32'd1);

    // Simultaneous store and fetch: store first, fetch after one idle cycle
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF);
    step();
    checkOutput("pri_ramWEN", 32'(ramWEN), 32'd1);
    checkOutput("pri_ramREN", 32'(ramREN), 32'd0);
    checkOutput("pri_ramaddr", ramaddr, 32'h100);
    checkOutput("pri_ramstore", ramstore, 32'hDEADBEEF);
    ramack = 1'b1;
    #1;
    checkOutput("pri_dwait_ack", 32'(dwait), 32'd0);
    checkOutput("pri_iwait_ack", 32'(iwait), 32'd1);
    dWEN = 1'b0;
    step();
    ramack = 1'b0;
    checkOutput("pri_idle_ramREN", 32'(ramREN), 32'd0);
    checkOutput("pri_idle_ramWEN", 32'(ramWEN), 32'd0);
    step();
    checkOutput("pri_fetch_ramREN", 32'(ramREN), 32'd1);
    checkOutput("pri_fetch_ramaddr", ramaddr, 32'h80);
    ramack = 1'b1;
    #1;
    checkOutput("pri_fetch_iwait", 32'(iwait), 32'd0);
    iREN = 1'b0;
    step();
    ramack = 1'b0;

    // Both held: four data grants, one fetch, then data again
    applyStimulus(1'b1, 32'hC0, 1'b1, 1'b0, 32'h200, '0);
    for (int g = 0; g < 6; g++) begin
      expAddr = (g == 4) ? 32'hC0 : 32'h200;
      step();
      checkOutput($sformatf("starve_addr_%0d", g), ramaddr, expAddr);
      checkOutput($sformatf("starve_ramREN_%0d", g), 32'(ramREN), 32'd1);
      ramack = 1'b1;
      #1;
      checkOutput($sformatf("starve_iwait_%0d", g), 32'(iwait), (g == 4) ? 32'd0 : 32'd1);
      checkOutput($sformatf("starve_dwait_%0d", g), 32'(dwait), (g == 4) ? 32'd1 : 32'd0);
      if (g == 5) begin
        iREN = 1'b0;
        dREN = 1'b0;
      end
      step();
      ramack = 1'b0;
    end

    // RAM never acks: strobe held TIMEOUT cycles, then abandon
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, '0, '0);
    step();
    iREN = 1'b0;
    strobeCycles = 0;
    iwaitLow     = 0;
    for (int c = 0; c < 70 && ramREN; c++) begin
      strobeCycles++;
      if (!iwait) iwaitLow++;
      step();
    end
    checkOutput("to_strobe_cycles", 32'(strobeCycles), 32'd64);
    checkOutput("to_iwait_never_low", 32'(iwaitLow), 32'd0);
    checkOutput("to_timeout_err", 32'(timeout_err), 32'd1);
    checkOutput("to_idle_ramREN", 32'(ramREN), 32'd0);

    // Ack on the last allowed cycle completes normally
    nRST = 1'b0;
    step();
    checkOutput("to_rst_clears_err", 32'(timeout_err), 32'd0);
    nRST = 1'b1;
    applyStimulus(1'b1, 32'h304, 1'b0, 1'b0, '0, '0);
    step();
    iREN = 1'b0;
    for (int c = 0; c < 63; c++) step();
    checkOutput("late_ramREN", 32'(ramREN), 32'd1);
    ramack  = 1'b1;
    ramload = 32'h11112222;
    #1;
    checkOutput("late_iwait", 32'(iwait), 32'd0);
    step();
    ramack = 1'b0;
    checkOutput("late_timeout_err", 32'(timeout_err), 32'd0);
    checkOutput("late_idle_ramREN", 32'(ramREN), 32'd0);

    // Reset two cycles into a store drops it silently
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h400, 32'h12345678);
    step();
    checkOutput("mid_ramWEN_c1", 32'(ramWEN), 32'd1);
    step();
    nRST = 1'b0;
    step();
    checkOutput("mid_rst_ramWEN", 32'(ramWEN), 32'd0);
    checkOutput("mid_rst_dwait", 32'(dwait), 32'd1);
    checkOutput("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
    checkOutput("mid_rst_ramaddr", ramaddr, 32'd0);
    dWEN = 1'b0;
    nRST = 1'b1;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h500, '0);
    step();
    checkOutput("post_ramREN", 32'(ramREN), 32'd1);
    checkOutput("post_ramWEN", 32'(ramWEN), 32'd0);
    checkOutput("post_ramaddr", ramaddr, 32'h500);
    ramack  = 1'b1;
    ramload = 32'hCAFEF00D;
    #1;
    checkOutput("post_dwait", 32'(dwait), 32'd0);
    checkOutput("post_dload", dload, 32'hCAFEF00D);
    dREN = 1'b0;
    step();
    ramack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
